// File: rtl/bit_deserializer_if.sv
// Handshake bundle between the serial bit source/word sink and bit_deserializer.
// The master side drives serial bits and downstream ready; the slave side returns words.
interface bit_deserializer_if #(
   parameter int WIDTH = 8
);
   logic             i_bit;
   logic             i_bitValid;
   logic             i_flush;
   logic             i_ready;
   logic             i_clrOverflow;
   logic [WIDTH-1:0] o_data;
   logic             o_valid;
   logic             o_busy;
   logic             o_overflow;

   modport master (
      output i_bit, i_bitValid, i_flush, i_ready, i_clrOverflow,
      input  o_data, o_valid, o_busy, o_overflow
   );

   modport slave (
      input  i_bit, i_bitValid, i_flush, i_ready, i_clrOverflow,
      output o_data, o_valid, o_busy, o_overflow
   );
endinterface

// File: rtl/bit_deserializer.sv
// Collects qualified serial bits into WIDTH-bit words with a one-word output holding
// register, valid/ready output handshake and a sticky overflow flag for dropped words.
module bit_deserializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   bit_deserializer_if.slave bus
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] sr_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] data_r;
   logic             valid_r;
   logic             overflow_r;

   logic [WIDTH-1:0] sr_next_s;
   logic             shift_s;
   logic             done_s;
   logic             drain_s;
   logic             load_s;
   logic             drop_s;

   // Next shift-register value and word completion / load / drop decisions.
   always_comb begin
      sr_next_s = sr_r;
      if (MSB_FIRST) begin
         sr_next_s = {sr_r[WIDTH-2:0], bus.i_bit};
      end else begin
         sr_next_s = {bus.i_bit, sr_r[WIDTH-1:1]};
      end
      shift_s = bus.i_bitValid & ~bus.i_flush;
      done_s  = shift_s & (cnt_r == CNT_W'(WIDTH - 1));
      drain_s = valid_r & bus.i_ready;
      // A completed word may load into a slot that is being drained on this same edge.
      load_s  = done_s & (~valid_r | drain_s);
      drop_s  = done_s & ~load_s;
   end

   // Shift register, bit counter, output register and overflow flag.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sr_r       <= {WIDTH{1'b0}};
         cnt_r      <= {CNT_W{1'b0}};
         data_r     <= {WIDTH{1'b0}};
         valid_r    <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         if (bus.i_flush) begin
            cnt_r <= {CNT_W{1'b0}};
         end else if (shift_s) begin
            sr_r  <= sr_next_s;
            cnt_r <= done_s ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));
         end else begin
            cnt_r <= cnt_r;
         end

         if (load_s) begin
            data_r  <= sr_next_s;
            valid_r <= 1'b1;
         end else if (drain_s) begin
            valid_r <= 1'b0;
         end else begin
            valid_r <= valid_r;
         end

         if (drop_s) begin
            overflow_r <= 1'b1;
         end else if (bus.i_clrOverflow) begin
            overflow_r <= 1'b0;
         end else begin
            overflow_r <= overflow_r;
         end
      end
   end

   assign bus.o_data     = data_r;
   assign bus.o_valid    = valid_r;
   assign bus.o_overflow = overflow_r;
   assign bus.o_busy     = (cnt_r != {CNT_W{1'b0}});
endmodule

// File: tb/tb_bit_deserializer.sv
// Directed bench: dut_a is MSB-first, dut_b is LSB-first, both WIDTH=8.
module tb_bit_deserializer;
   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   bit_deserializer_if #(.WIDTH(8)) bus_a ();
   bit_deserializer_if #(.WIDTH(8)) bus_b ();

   bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (.i_clk(i_clk), .i_rst(i_rst), .bus(bus_a));
   bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (.i_clk(i_clk), .i_rst(i_rst), .bus(bus_b));

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_a(input logic b);
      bus_a.i_bit      = b;
      bus_a.i_bitValid = 1'b1;
      tick();
      bus_a.i_bitValid = 1'b0;
   endtask

   task automatic send_word_a(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) send_a(w[i]);
   endtask

   initial begin
      logic [7:0] lsb_bits;
      bus_a.i_bit = 1'b0; bus_a.i_bitValid = 1'b0; bus_a.i_flush = 1'b0;
      bus_a.i_ready = 1'b0; bus_a.i_clrOverflow = 1'b0;
      bus_b.i_bit = 1'b0; bus_b.i_bitValid = 1'b0; bus_b.i_flush = 1'b0;
      bus_b.i_ready = 1'b1; bus_b.i_clrOverflow = 1'b0;
      tick(); tick();
      i_rst = 1'b0;
      check("rst_data",  32'(bus_a.o_data), 32'h0);
      check("rst_valid", 32'(bus_a.o_valid), 32'h0);
      check("rst_busy",  32'(bus_a.o_busy), 32'h0);
      check("rst_ovf",   32'(bus_a.o_overflow), 32'h0);

      // Basic MSB-first word with ready held high.
      bus_a.i_ready = 1'b1;
      send_word_a(8'hA5);
      check("a5_data",  32'(bus_a.o_data), 32'hA5);
      check("a5_valid", 32'(bus_a.o_valid), 32'h1);
      check("a5_busy",  32'(bus_a.o_busy), 32'h0);
      tick();
      check("a5_drained", 32'(bus_a.o_valid), 32'h0);

      // LSB-first with 3-cycle gaps; counter must hold across each gap.
      lsb_bits = 8'b1011_0100;
      for (int i = 0; i < 8; i++) begin
         bus_b.i_bit = lsb_bits[i];
         bus_b.i_bitValid = 1'b1;
         tick();
         bus_b.i_bitValid = 1'b0;
         if (i < 7) begin
            tick(); tick(); tick();
            check($sformatf("gap_cnt%0d", i), 32'(dut_b.cnt_r), 32'(i + 1));
         end
      end
      check("b4_data",  32'(bus_b.o_data), 32'hB4);
      check("b4_valid", 32'(bus_b.o_valid), 32'h1);

      // Back-pressure: second word is dropped, first is held.
      bus_a.i_ready = 1'b0;
      send_word_a(8'h11);
      check("bp_data1",  32'(bus_a.o_data), 32'h11);
      check("bp_valid1", 32'(bus_a.o_valid), 32'h1);
      check("bp_ovf1",   32'(bus_a.o_overflow), 32'h0);
      send_word_a(8'h22);
      check("bp_data2",  32'(bus_a.o_data), 32'h11);
      check("bp_valid2", 32'(bus_a.o_valid), 32'h1);
      check("bp_ovf2",   32'(bus_a.o_overflow), 32'h1);
      bus_a.i_clrOverflow = 1'b1;
      tick();
      bus_a.i_clrOverflow = 1'b0;
      check("clr_ovf",  32'(bus_a.o_overflow), 32'h0);
      check("clr_data", 32'(bus_a.o_data), 32'h11);

      // Same-edge drain: 8'h33 completes on the edge that accepts 8'h11.
      for (int i = 7; i >= 1; i--) send_a(logic'((8'h33 >> i) & 8'h01));
      check("sd_hold", 32'(bus_a.o_data), 32'h11);
      bus_a.i_ready = 1'b1;
      send_a(1'b1);
      check("sd_data",  32'(bus_a.o_data), 32'h33);
      check("sd_valid", 32'(bus_a.o_valid), 32'h1);
      check("sd_ovf",   32'(bus_a.o_overflow), 32'h0);
      tick();
      check("sd_drained", 32'(bus_a.o_valid), 32'h0);

      // Flush with a simultaneous valid bit discards that bit.
      send_a(1'b1); send_a(1'b1); send_a(1'b1);
      check("fl_busy_pre", 32'(bus_a.o_busy), 32'h1);
      bus_a.i_flush = 1'b1;
      send_a(1'b1);
      bus_a.i_flush = 1'b0;
      check("fl_busy", 32'(bus_a.o_busy), 32'h0);
      send_word_a(8'hC3);
      check("fl_data",  32'(bus_a.o_data), 32'hC3);
      check("fl_valid", 32'(bus_a.o_valid), 32'h1);
      tick();

      // Asynchronous reset mid-word while holding an undrained word.
      bus_a.i_ready = 1'b0;
      send_word_a(8'h5A);
      for (int i = 0; i < 5; i++) send_a(1'b1);
      check("mr_busy_pre",  32'(bus_a.o_busy), 32'h1);
      check("mr_valid_pre", 32'(bus_a.o_valid), 32'h1);
      #2 i_rst = 1'b1;
      #1;
      check("mr_data",  32'(bus_a.o_data), 32'h0);
      check("mr_valid", 32'(bus_a.o_valid), 32'h0);
      check("mr_busy",  32'(bus_a.o_busy), 32'h0);
      check("mr_ovf",   32'(bus_a.o_overflow), 32'h0);
      #1 i_rst = 1'b0;
      tick();
      bus_a.i_ready = 1'b1;
      send_word_a(8'h96);
      check("mr_after_data",  32'(bus_a.o_data), 32'h96);
      check("mr_after_valid", 32'(bus_a.o_valid), 32'h1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/bit_deserializer.md
# bit_deserializer

Downstream consumer of the registered single-bit decision-tree output. Collects qualified serial bits into WIDTH-bit words and presents each completed word on a valid/ready output port. Holds one completed word while the next is being shifted in. Flags dropped words with a sticky overflow flag.

## Interface
- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1: first received bit lands in o_data[WIDTH-1]; 0: first received bit lands in o_data[0].
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_bit  input  1  serial data; driven by the decision-tree registered output.
- i_bitValid  input  1  i_bit is sampled on this edge; the upstream control generator aligns it with the registered bit.
- i_flush  input  1  discards the partial word.
- o_data  output  WIDTH  completed word; stable while o_valid is high.
- o_valid  output  1  o_data holds an unconsumed word.
- i_ready  input  1  downstream accepts; a transfer occurs on an edge where o_valid and i_ready are both high.
- o_busy  output  1  partial word in progress (bit count != 0).
- o_overflow  output  1  sticky: a completed word was dropped.
- i_clrOverflow  input  1  clears o_overflow.

## Operation
- State:
  - shift register sr[WIDTH-1:0].
  - bit counter cnt, $clog2(WIDTH) bits, range 0..WIDTH-1.
  - output register (data + valid).
  - overflow flag.
- Shift, MSB_FIRST=1: sr <= {sr[WIDTH-2:0], i_bit}.
- Shift, MSB_FIRST=0: sr <= {i_bit, sr[WIDTH-1:1]}.
- Each edge with i_bitValid=1 and i_flush=0:
  - shift i_bit into sr.
  - if cnt==WIDTH-1, the word completes and cnt wraps to 0; otherwise cnt increments.
- Word completion:
  - the completed word (sr with the new bit already applied) is loaded into the output register if it is empty, or if it is being drained on the same edge (o_valid & i_ready).
  - otherwise the new word is dropped, o_overflow sets, and o_data keeps the old word.
- Output handshake:
  - o_valid clears on a transfer edge unless a new word loads on that same edge.
  - o_data never changes while o_valid=1 and i_ready=0.
- Flush:
  - i_flush=1 sets cnt to 0 and discards any i_bitValid on the same edge.
  - flush does not touch the output register or o_overflow.
- Overflow flag:
  - i_clrOverflow=1 clears o_overflow.
  - a set and a clear on the same edge: set wins.
- o_busy = (cnt != 0), combinational from the register.

## Timing
- Reset values: o_data=0, o_valid=0, o_busy=0, o_overflow=0, cnt=0, sr=0.
- Reset is asynchronous; asserting it mid-word or mid-handshake loses all state immediately.
- Latency: o_valid rises on the edge that samples the WIDTH-th valid bit and is visible the following cycle.
- Throughput: one bit per cycle sustained; one word per WIDTH cycles with no loss as long as i_ready is seen at least once per WIDTH cycles.
- Gaps: i_bitValid may deassert for any number of cycles; cnt and sr hold during gaps.
- i_ready may be high while o_valid=0; this has no effect.
- There is no combinational path from any input to o_valid or o_data.

## Test plan
- Reset, MSB_FIRST=1, WIDTH=8: send 1,0,1,0,0,1,0,1 on consecutive cycles with i_ready=1 -> o_data=8'hA5, o_valid high for exactly one cycle, o_busy low afterwards.
- MSB_FIRST=0: send 0,0,1,0,1,1,0,1 with 3-cycle gaps of i_bitValid=0 between bits -> o_data=8'hB4, and cnt holds across every gap.
- Back-pressure, i_ready=0: send words 8'h11 then 8'h22 back-to-back -> o_data stays 8'h11, o_valid stays 1, o_overflow=1 on the cycle after the 16th bit; then i_clrOverflow -> o_overflow=0.
- Same-edge drain: complete 8'h33 on the exact edge where 8'h11 is accepted (i_ready=1) -> no overflow; the next cycle shows o_data=8'h33 with o_valid=1.
- Flush: send 3 bits, then assert i_flush together with i_bitValid=1 -> o_busy=0 and the bit is discarded; the next 8 bits 8'hC3 give o_data=8'hC3.
- Reset mid-word: after 5 bits, assert i_rst asynchronously between clock edges -> all outputs read 0 immediately; after release, a fresh 8-bit word decodes correctly.
